temporizador_core: RTL and testbench
====================================

Name: temporizador_core

Overview:
Programmable seconds timer for the coffee-maker controller.
- Divides the 100 MHz system clock to a 1 Hz tick.
- On a start pulse, latches a 2-bit duration in seconds (0..3), counts elapsed seconds and flags expiry.
- Exposes its internal divider and edge-detect signals as debug outputs for the controller FSM and for simulation.

Parameters:
- TICK_HALF, default 50_000_000: clk_100MHz cycles per half period of clk_1Hz; the full tick period is 2*TICK_HALF cycles. Benches override it to 2.

Ports:
- clk_100MHz  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  2  timer duration in seconds; sampled only when start_timer is seen.
- start_timer  in  1  synchronous start/restart request; a 1-cycle pulse is sufficient.
- t_expired  out  1  level; high from expiry until the next start or reset.
- on  out  1  timer armed; high from start until expiry.
- counting  out  1  high while on=1 and latched value != 0.
- counter  out  2  elapsed whole seconds since the last start.
- clk_1Hz  out  1  divided clock; a register, not a gated clock.
- add_one  out  1  clk_1Hz delayed by one cycle.
- add_one_last  out  1  add_one delayed by one cycle.

Behaviour:
- Reset (rst_n=0, asynchronous) clears all outputs and internal registers to 0: divider count, latched value, counter, on, t_expired, clk_1Hz, add_one, add_one_last.
- Internal registers:
  - div_cnt, width $clog2(TICK_HALF).
  - val_l, 2 bits.
- Start (start_timer=1 at edge E0). At E0, regardless of current state, including a restart mid-count:
  - val_l<=value; counter<=0; t_expired<=0; div_cnt<=0.
  - clk_1Hz<=1, add_one<=1, add_one_last<=1. Presetting all three prevents a spurious tick.
  - If value!=0: on<=1.
  - If value==0: t_expired<=1 and on stays 0, i.e. immediate expiry.
- Divider, while on=1:
  - Each edge: div_cnt increments.
  - At the edge where div_cnt==TICK_HALF-1: div_cnt<=0 and clk_1Hz toggles.
  - The first falling edge of clk_1Hz occurs at E_TICK_HALF and the first rise at E_2*TICK_HALF. Every rise is exactly 1 s after the previous one (or after the start).
- Divider, while on=0: div_cnt held at 0 and clk_1Hz<=0.
- Edge detect: every cycle, add_one<=clk_1Hz and add_one_last<=add_one.
- Tick condition: add_one=1 and add_one_last=0, while on=1.
- On each tick:
  - counter<=counter+1.
  - If counter+1==val_l, on the same edge: t_expired<=1 and on<=0.
- Latency: counter reaches n at edge E(2n*TICK_HALF+2) after start edge E0. t_expired rises on the same edge counter reaches val_l.
- After expiry:
  - counter holds at val_l; no wrap-around, since counting stops.
  - t_expired stays high until the next start or reset.
- counting is combinational: on && (val_l!=0).
- Changes to value while armed are ignored; only val_l is used.
- start_timer held high for several cycles restarts on every such cycle. Counting begins after its last high cycle.

Test Plan:
- Reset, TICK_HALF=2: rst_n low then high -> all outputs 0; with no start, outputs stay 0 for 50 cycles.
- value=1, 1-cycle start pulse at E0 -> on=1 and counting=1 from E0 until E6. At E6: counter=1, t_expired=1, on=0.
- value=3, start at E0 -> counter =1 at E6, =2 at E10, =3 at E14. t_expired=1 and on=0 at E14; counter then holds 3.
- value=0, start at E0 -> t_expired=1 at E0, on=0, counting=0, counter=0.
- Restart: value=3, start at E0; at E8 apply start with value=2 -> at E8 counter=0 and t_expired=0; counter=1 at E14, =2 at E18 with t_expired=1.
- Reset mid-count: rst_n=0 asynchronously at E9 of a value=3 run -> counter, on, clk_1Hz and t_expired all 0 immediately; no further ticks until a new start.

Source files
------------

// File: rtl/temporizador_core.sv
// Programmable seconds timer: divides the system clock to a 1 Hz tick, counts
// elapsed seconds after a start request and flags expiry of a 0..3 s duration.
module temporizador_core #(
    parameter int TICK_HALF = 50_000_000
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic [1:0] value,
    input  logic       start_timer,
    output logic       t_expired,
    output logic       on,
    output logic       counting,
    output logic [1:0] counter,
    output logic       clk_1Hz,
    output logic       add_one,
    output logic       add_one_last
);

    localparam int DIV_W = (TICK_HALF > 1) ? $clog2(TICK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_HALF - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       val_l;
    logic [1:0]       counter_nxt;
    logic             tick;

    assign counter_nxt = counter + 2'd1;
    assign tick        = on && add_one && !add_one_last;
    assign counting    = on && (val_l != 2'd0);

    // NOTE: all state updates use <= so every branch sees the pre-edge values,
    // which is what makes the one-cycle edge-detect pipeline work.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            val_l        <= 2'd0;
            counter      <= 2'd0;
            on           <= 1'b0;
            t_expired    <= 1'b0;
            clk_1Hz      <= 1'b0;
            add_one      <= 1'b0;
            add_one_last <= 1'b0;
        end else if (start_timer) begin
            // Presetting the divider output and both edge-detect stages high
            // suppresses a false rising edge right after a (re)start.
            val_l        <= value;
            counter      <= 2'd0;
            div_cnt      <= '0;
            clk_1Hz      <= 1'b1;
            add_one      <= 1'b1;
            add_one_last <= 1'b1;
            on           <= (value != 2'd0);
            t_expired    <= (value == 2'd0);
        end else begin
            add_one      <= clk_1Hz;
            add_one_last <= add_one;

            if (on) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    clk_1Hz <= !clk_1Hz;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
                clk_1Hz <= 1'b0;
            end

            // Counting stops at expiry, so the counter never wraps past val_l.
            if (tick) begin
                counter <= counter_nxt;
                if (counter_nxt == val_l) begin
                    t_expired <= 1'b1;
                    on        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_temporizador_core.sv
// Self-checking bench for temporizador_core with TICK_HALF=2: a per-cycle
// vector table plus directed multi-cycle sequences.
module tb_temporizador_core;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic [1:0] value;
    logic       start_timer;
    logic       t_expired, on, counting, clk_1Hz, add_one, add_one_last;
    logic [1:0] counter;

    int checks   = 0;
    int failures = 0;

    temporizador_core #(.TICK_HALF(2)) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .value       (value),
        .start_timer (start_timer),
        .t_expired   (t_expired),
        .on          (on),
        .counting    (counting),
        .counter     (counter),
        .clk_1Hz     (clk_1Hz),
        .add_one     (add_one),
        .add_one_last(add_one_last)
    );

    always #5 clk_100MHz = !clk_100MHz;

    typedef struct {
        logic       start;
        logic [1:0] val;
        logic       e_on;
        logic       e_counting;
        logic [1:0] e_counter;
        logic       e_expired;
        logic       e_clk;
        logic       e_ao;
        logic       e_aol;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic cyc();
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic start(input logic [1:0] v);
        value       = v;
        start_timer = 1'b1;
        cyc();
        start_timer = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_on"},        32'(on),           0);
        check({tag, "_expired"},   32'(t_expired),    0);
        check({tag, "_counter"},   32'(counter),      0);
        check({tag, "_clk1hz"},    32'(clk_1Hz),      0);
        check({tag, "_addone"},    32'(add_one),      0);
        check({tag, "_addlast"},   32'(add_one_last), 0);
        check({tag, "_counting"},  32'(counting),     0);
    endtask

    initial begin
        // value=1 run from E0 to E8, then a value=0 start and one idle cycle.
        vecs[0]  = '{1, 2'd1, 1, 1, 2'd0, 0, 1, 1, 1};
        vecs[1]  = '{0, 2'd1, 1, 1, 2'd0, 0, 1, 1, 1};
        vecs[2]  = '{0, 2'd1, 1, 1, 2'd0, 0, 0, 1, 1};
        vecs[3]  = '{0, 2'd1, 1, 1, 2'd0, 0, 0, 0, 1};
        vecs[4]  = '{0, 2'd1, 1, 1, 2'd0, 0, 1, 0, 0};
        vecs[5]  = '{0, 2'd1, 1, 1, 2'd0, 0, 1, 1, 0};
        vecs[6]  = '{0, 2'd1, 0, 0, 2'd1, 1, 0, 1, 1};
        vecs[7]  = '{0, 2'd1, 0, 0, 2'd1, 1, 0, 0, 1};
        vecs[8]  = '{0, 2'd1, 0, 0, 2'd1, 1, 0, 0, 0};
        vecs[9]  = '{1, 2'd0, 0, 0, 2'd0, 1, 1, 1, 1};
        vecs[10] = '{0, 2'd0, 0, 0, 2'd0, 1, 0, 1, 1};

        rst_n       = 1'b0;
        value       = 2'd0;
        start_timer = 1'b0;
        cycles(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (i % 10 == 9) check_all_zero($sformatf("idle%0d", i));
        end

        for (int i = 0; i < 11; i++) begin
            value       = vecs[i].val;
            start_timer = vecs[i].start;
            cyc();
            check($sformatf("v%0d_on", i),       32'(on),           32'(vecs[i].e_on));
            check($sformatf("v%0d_counting", i), 32'(counting),     32'(vecs[i].e_counting));
            check($sformatf("v%0d_counter", i),  32'(counter),      32'(vecs[i].e_counter));
            check($sformatf("v%0d_expired", i),  32'(t_expired),    32'(vecs[i].e_expired));
            check($sformatf("v%0d_clk1hz", i),   32'(clk_1Hz),      32'(vecs[i].e_clk));
            check($sformatf("v%0d_addone", i),   32'(add_one),      32'(vecs[i].e_ao));
            check($sformatf("v%0d_addlast", i),  32'(add_one_last), 32'(vecs[i].e_aol));
        end
        start_timer = 1'b0;

        // value=3 run; value changes while armed must be ignored.
        start(2'd3);
        value = 2'd1;
        cycles(5);
        check("v3_e5_counter", 32'(counter), 0);
        cyc();
        check("v3_e6_counter", 32'(counter), 1);
        check("v3_e6_expired", 32'(t_expired), 0);
        cycles(4);
        check("v3_e10_counter", 32'(counter), 2);
        check("v3_e10_on", 32'(on), 1);
        cycles(3);
        check("v3_e13_expired", 32'(t_expired), 0);
        cyc();
        check("v3_e14_counter", 32'(counter), 3);
        check("v3_e14_expired", 32'(t_expired), 1);
        check("v3_e14_on", 32'(on), 0);
        cycles(12);
        check("v3_hold_counter", 32'(counter), 3);
        check("v3_hold_expired", 32'(t_expired), 1);

        // Restart mid-count at E8 with value=2.
        start(2'd3);
        cycles(7);
        start(2'd2);
        check("rs_e8_counter", 32'(counter), 0);
        check("rs_e8_expired", 32'(t_expired), 0);
        check("rs_e8_on", 32'(on), 1);
        cycles(5);
        check("rs_e13_counter", 32'(counter), 0);
        cyc();
        check("rs_e14_counter", 32'(counter), 1);
        cycles(3);
        check("rs_e17_expired", 32'(t_expired), 0);
        cyc();
        check("rs_e18_counter", 32'(counter), 2);
        check("rs_e18_expired", 32'(t_expired), 1);
        check("rs_e18_on", 32'(on), 0);

        // Asynchronous reset just after E9 of a value=3 run.
        start(2'd3);
        cycles(8);
        check("ar_e8_counter", 32'(counter), 1);
        @(posedge clk_100MHz);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("ar_now");
        cycles(2);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check($sformatf("ar_post%0d_counter", i), 32'(counter), 0);
            check($sformatf("ar_post%0d_on", i), 32'(on), 0);
        end
        check_all_zero("ar_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
